// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: decodes set-2 make codes for hex keys 0-F into a
// small digit FIFO read through a single 32-bit MMIO word.
module ps2_key_rx #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        clr_err,
    output logic [31:0] key_data,
    output logic        key_valid,
    output logic        overflow,
    output logic        frame_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          pclk_s1_q, pclk_s2_q, pclk_prev_q, pdat_s1_q, pdat_s2_q;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d, frame_err_q, frame_err_d;

    logic       fall, push, ferr_ev, map_hit, full, pop, wr;
    logic [3:0] map_dig;

    assign fall = pclk_prev_q & ~pclk_s2_q;

    always_comb begin
        map_hit = 1'b1;
        map_dig = 4'h0;
        case (shift_q)
            8'h45: map_dig = 4'h0;
            8'h16: map_dig = 4'h1;
            8'h1E: map_dig = 4'h2;
            8'h26: map_dig = 4'h3;
            8'h25: map_dig = 4'h4;
            8'h2E: map_dig = 4'h5;
            8'h36: map_dig = 4'h6;
            8'h3D: map_dig = 4'h7;
            8'h3E: map_dig = 4'h8;
            8'h46: map_dig = 4'h9;
            8'h1C: map_dig = 4'hA;
            8'h32: map_dig = 4'hB;
            8'h21: map_dig = 4'hC;
            8'h23: map_dig = 4'hD;
            8'h24: map_dig = 4'hE;
            8'h2B: map_dig = 4'hF;
            default: map_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        to_d    = to_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        push    = 1'b0;
        ferr_ev = 1'b0;
        if (fall) begin
            to_d = '0;
            case (state_q)
                IDLE: begin
                    if (!pdat_s2_q) begin
                        state_d = DATA;
                        bcnt_d  = 3'd0;
                    end else begin
                        ferr_ev = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {pdat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = pdat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (pdat_s2_q && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (ext_q || brk_q) begin
                            // Extended keys and break codes never produce digits.
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end else begin
                            push = map_hit;
                        end
                    end else begin
                        ferr_ev = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                to_d    = '0;
                shift_d = '0;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                ferr_ev = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // A push into a full FIFO only lands when a pop frees the head slot.
    assign full = (cnt_q == CW'(FIFO_DEPTH));
    assign pop  = rd_en && (cnt_q != '0);
    assign wr   = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!wr && pop) cnt_d = cnt_q - 1'b1;
        overflow_d  = (overflow_q & ~clr_err) | (push & full & ~pop);
        frame_err_d = (frame_err_q & ~clr_err) | ferr_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s1_q   <= 1'b1;
            pclk_s2_q   <= 1'b1;
            pclk_prev_q <= 1'b1;
            pdat_s1_q   <= 1'b1;
            pdat_s2_q   <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= '0;
            bcnt_q      <= '0;
            par_q       <= 1'b0;
            to_q        <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            pclk_s1_q   <= ps2_clk;
            pclk_s2_q   <= pclk_s1_q;
            pclk_prev_q <= pclk_s2_q;
            pdat_s1_q   <= ps2_data;
            pdat_s2_q   <= pdat_s1_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcnt_q      <= bcnt_d;
            par_q       <= par_d;
            to_q        <= to_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= map_dig;
    end

    assign key_valid = (cnt_q != '0);
    assign key_data  = key_valid ? {1'b1, 27'd0, mem_q[rd_ptr_q]} : 32'd0;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000, is the number of idle clk cycles mid-frame after which a partial frame is aborted.
REQ-002 Parameter FIFO_DEPTH, default 4, is the hex-digit FIFO depth; it is a power of 2 and at least 2.
REQ-003 clk  in  1  CPU clock (cpu_clk domain); all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  raw PS/2 clock from the pad, asynchronous.
REQ-006 ps2_data  in  1  raw PS/2 data from the pad, asynchronous.
REQ-007 rd_en  in  1  one-cycle pop strobe, driven by the memory/IO mapper on an ioRead of the keyboard address.
REQ-008 clr_err  in  1  one-cycle strobe that clears the overflow and frame_err flags.
REQ-009 key_data  out  32  MMIO read word: bit31 = FIFO non-empty, bits[3:0] = head digit, all other bits 0; the word is all zeros when the FIFO is empty.
REQ-010 key_valid  out  1  FIFO non-empty.
REQ-011 overflow  out  1  sticky flag: a digit was dropped because the FIFO was full.
REQ-012 frame_err  out  1  sticky flag: a frame had a bad start, parity or stop bit, or timed out.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge is detected when the previous synchronized clock is 1 and the current is 0.
REQ-014 Frame FSM states SHALL be IDLE, DATA, PARITY and STOP; on every falling edge, synchronized ps2_data is sampled in the same cycle.
REQ-015 IDLE: on an edge, data=0 -> DATA with bit count 0; data=1 -> stay IDLE and set frame_err.
REQ-016 DATA: shift LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: store the bit -> STOP.
REQ-018 STOP: the frame is good when stop=1 and the 8 data bits plus parity have odd parity; otherwise set frame_err and discard the byte. Both cases -> IDLE.
REQ-019 A timeout counter SHALL reset on each edge; in any state other than IDLE, reaching TIMEOUT_CYC -> IDLE, set frame_err, discard the partial byte, and clear the prefix flags.
REQ-020 Byte handling for a good frame, in the STOP cycle:
- E0 sets the ext flag.
- F0 sets the brk flag.
- Any other byte with brk or ext set is discarded, and both flags clear.
- Otherwise, a set-2 make code maps to a digit: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9, 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F.
- Unmapped codes are ignored.
REQ-021 A mapped digit SHALL be written to the FIFO in the STOP cycle; key_valid and key_data reflect it on the next cycle (latency 1 clk from stop-bit edge detection).
REQ-022 Pop SHALL occur on rd_en when the FIFO is non-empty; the new head is visible the next cycle. rd_en on an empty FIFO is ignored and changes no state.
REQ-023 Push when full without a simultaneous pop: the digit is dropped and overflow is set.
REQ-024 Push and pop in the same cycle when full: both succeed, occupancy is unchanged, and overflow is not set.
REQ-025 Push and pop in the same cycle when empty: the digit is stored and the pop is ignored.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count range is 0..FIFO_DEPTH.
REQ-027 clr_err clears overflow and frame_err. If an error event occurs in the same cycle as clr_err, the flag is set (set wins).
REQ-028 key_data SHALL be driven combinationally from the registered FIFO head and count; there is no combinational path from ps2 inputs to any output.

Reset
REQ-029 While rst=1 at a clock edge:
- FSM returns to IDLE.
- Shift register, bit count, timeout counter, ext and brk are cleared.
- FIFO is emptied.
- overflow and frame_err are cleared.
- Synchronizers are loaded with 1 (line idle).
REQ-030 Reset outputs: key_data=32'h0, key_valid=0, overflow=0, frame_err=0.
REQ-031 A frame in progress when rst is asserted SHALL be abandoned; bits arriving after rst deasserts are parsed as a new frame only from a start bit seen in IDLE.

Verification
REQ-032 Send a frame with byte 0x1E and correct parity -> key_valid=1 one clk after the stop edge and key_data=32'h8000_0002; pulse rd_en -> key_data=32'h0 and key_valid=0 on the next clk.
REQ-033 Send 0x1C, then F0 1C, then E0 45 -> the FIFO holds exactly one entry, key_data=32'h8000_000A, and ext and brk are both clear afterwards.
REQ-034 Send 5 mapped make codes (0x16, 0x1E, 0x26, 0x25, 0x2E) with FIFO_DEPTH=4 and no pops -> overflow=1; popping 4 times yields 1, 2, 3, 4, then key_data=0. A 5th push with a simultaneous rd_en when full -> no overflow.
REQ-035 Send a frame with a wrong parity bit -> frame_err=1 and no push. Stop ps2_clk after 4 data bits for more than TIMEOUT_CYC cycles -> frame_err=1 and FSM back in IDLE; a following valid 0x45 frame pushes 0. clr_err -> frame_err=0.
REQ-036 Assert rst mid-frame after 5 data bits, then release -> all outputs are zero; a complete 0x2B frame sent afterwards -> key_data=32'h8000_000F.
